// File: rtl/cpu_run_ctrl_if.sv
// Signal bundle between the run-control sequencer and its environment:
// divided clocks, run/halt/step requests, breakpoint compare and CPU strobe.
interface cpu_run_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic             OCLK_IN;
    logic             CLK1_IN;
    logic             CLK2_IN;
    logic [1:0]       SPEED;
    logic             RUN_REQ;
    logic             HALT_REQ;
    logic             STEP_BTN;
    logic             HALT_IN;
    logic             BP_EN;
    logic [31:0]      BP_ADDR;
    logic [31:0]      PC;
    logic             CPU_EN;
    logic [1:0]       STATE;
    logic             RUNNING;
    logic [CNT_W-1:0] CYCLES;

    modport master (
        output OCLK_IN, CLK1_IN, CLK2_IN, SPEED, RUN_REQ, HALT_REQ, STEP_BTN,
        output HALT_IN, BP_EN, BP_ADDR, PC,
        input  CPU_EN, STATE, RUNNING, CYCLES
    );

    modport slave (
        input  OCLK_IN, CLK1_IN, CLK2_IN, SPEED, RUN_REQ, HALT_REQ, STEP_BTN,
        input  HALT_IN, BP_EN, BP_ADDR, PC,
        output CPU_EN, STATE, RUNNING, CYCLES
    );
endinterface

// File: rtl/cpu_run_ctrl.sv
// Run-control sequencer: turns a selected divided clock into one-CLK CPU_EN strobes,
// gated by run/halt/step requests, a debounced step button, CPU halt and a PC breakpoint.
module cpu_run_ctrl #(
    parameter int unsigned DEB_SAMPLES = 3,
    parameter int unsigned CNT_W       = 16
) (
    input logic           CLK,
    input logic           nRST,
    cpu_run_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StRun    = 2'b01,
        StStep   = 2'b10,
        StHalted = 2'b11
    } state_e;

    localparam logic [3:0] DebTarget = 4'(DEB_SAMPLES);

    state_e           state_q, state_d;
    logic             cpu_en_q, cpu_en_d;
    logic             skip_q, skip_d;
    logic [CNT_W-1:0] cycles_q, cycles_d;

    logic       src_sel;
    logic       src_s1_q, src_s2_q;
    logic [1:0] speed_q;
    logic       tick;

    logic       c1_s1_q, c1_s2_q;
    logic [3:0] deb_cnt_q, deb_cnt_d;
    logic       btn_stable_q, btn_stable_d;
    logic       btn_prev_q;
    logic       press;
    logic       hit;

    always_comb begin
        src_sel = 1'b0;
        case (bus.SPEED)
            2'b00:   src_sel = bus.OCLK_IN;
            2'b01:   src_sel = bus.CLK1_IN;
            2'b10:   src_sel = bus.CLK2_IN;
            default: src_sel = 1'b0;
        endcase
    end

    // A SPEED change suppresses the tick for that cycle so the new source's history can settle.
    assign tick = (bus.SPEED == speed_q) &
                  ((bus.SPEED == 2'b11) | (src_s1_q & ~src_s2_q));

    always_comb begin
        deb_cnt_d    = deb_cnt_q;
        btn_stable_d = btn_stable_q;
        if (c1_s1_q & ~c1_s2_q) begin
            if (bus.STEP_BTN != btn_stable_q) begin
                if (deb_cnt_q + 4'd1 == DebTarget) begin
                    btn_stable_d = bus.STEP_BTN;
                    deb_cnt_d    = 4'd0;
                end else begin
                    deb_cnt_d = deb_cnt_q + 4'd1;
                end
            end else begin
                deb_cnt_d = 4'd0;
            end
        end
    end

    assign press = btn_stable_q & ~btn_prev_q;

    // skip masks the breakpoint until the first strobe after entering RUN or STEP.
    assign hit = bus.BP_EN & (bus.PC == bus.BP_ADDR) & ~skip_q;

    always_comb begin
        state_d  = state_q;
        cpu_en_d = 1'b0;
        skip_d   = skip_q;
        if (bus.HALT_REQ) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.RUN_REQ) begin
                        state_d = StRun;
                        skip_d  = 1'b1;
                    end else if (press) begin
                        state_d = StStep;
                        skip_d  = 1'b1;
                    end
                end
                StRun, StStep: begin
                    if (bus.HALT_IN || (tick && hit)) begin
                        state_d = StHalted;
                    end else if (tick) begin
                        cpu_en_d = 1'b1;
                        skip_d   = 1'b0;
                        if (state_q == StStep) begin
                            state_d = StIdle;
                        end
                    end
                end
                StHalted: begin
                    state_d = StHalted;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    assign cycles_d = cpu_en_d ? cycles_q + CNT_W'(1) : cycles_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q      <= StIdle;
            cpu_en_q     <= 1'b0;
            skip_q       <= 1'b0;
            cycles_q     <= '0;
            src_s1_q     <= 1'b0;
            src_s2_q     <= 1'b0;
            speed_q      <= 2'b00;
            c1_s1_q      <= 1'b0;
            c1_s2_q      <= 1'b0;
            deb_cnt_q    <= 4'd0;
            btn_stable_q <= 1'b0;
            btn_prev_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cpu_en_q     <= cpu_en_d;
            skip_q       <= skip_d;
            cycles_q     <= cycles_d;
            src_s1_q     <= src_sel;
            src_s2_q     <= src_s1_q;
            speed_q      <= bus.SPEED;
            c1_s1_q      <= bus.CLK1_IN;
            c1_s2_q      <= c1_s1_q;
            deb_cnt_q    <= deb_cnt_d;
            btn_stable_q <= btn_stable_d;
            btn_prev_q   <= btn_stable_q;
        end
    end

    assign bus.CPU_EN  = cpu_en_q;
    assign bus.STATE   = state_q;
    assign bus.RUNNING = (state_q == StRun);
    assign bus.CYCLES  = cycles_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Scoreboard bench for cpu_run_ctrl: a behavioural model pushes per-cycle expectations,
// a monitor pops and compares them; directed phases add spec-level count checks.
module tb_cpu_run_ctrl;

    localparam int CntW       = 4;
    localparam int DebSamples = 3;
    localparam int ModeIdle   = 0;
    localparam int ModeRun    = 1;
    localparam int ModeStep   = 2;
    localparam int ModeHalted = 3;

    logic CLK = 1'b0;
    logic nRST;

    always #5 CLK = ~CLK;

    cpu_run_ctrl_if #(.CNT_W(CntW)) bus ();

    cpu_run_ctrl #(
        .DEB_SAMPLES(DebSamples),
        .CNT_W      (CntW)
    ) dut (
        .CLK (CLK),
        .nRST(nRST),
        .bus (bus)
    );

    typedef struct packed {
        logic            en;
        logic [1:0]      st;
        logic [CntW-1:0] cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   strobes  = 0;
    int   step_entries = 0;
    logic [1:0] st_prev = 2'b00;

    logic        pc_follow = 1'b0;
    logic [31:0] pc_set    = 32'd0;

    // Reference model state: operating mode, strobe count, and short input histories.
    int m_mode, m_cycles, m_speed_prev, b_run;
    bit m_en, m_skip, src_now, src_old, c1_now, c1_old, b_stable, b_prev;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = ModeIdle; m_cycles = 0; m_speed_prev = 0; b_run = 0;
        m_en = 0; m_skip = 0; src_now = 0; src_old = 0; c1_now = 0; c1_old = 0;
        b_stable = 0; b_prev = 0;
    endtask

    function automatic bit pick_src(logic [1:0] sp, logic o, logic c1, logic c2);
        case (sp)
            2'b00:   return o;
            2'b01:   return c1;
            2'b10:   return c2;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_edge();
        bit tick, press, hit, active;
        tick = (bus.SPEED == 2'b11) || (src_now && !src_old);
        if (int'(bus.SPEED) != m_speed_prev) tick = 0;
        press  = b_stable && !b_prev;
        hit    = bus.BP_EN && (bus.PC == bus.BP_ADDR) && !m_skip;
        active = (m_mode == ModeRun) || (m_mode == ModeStep);

        b_prev = b_stable;
        if (c1_now && !c1_old) begin
            if (bus.STEP_BTN != b_stable) begin
                b_run++;
                if (b_run == DebSamples) begin
                    b_stable = bus.STEP_BTN;
                    b_run    = 0;
                end
            end else begin
                b_run = 0;
            end
        end
        src_old = src_now;
        src_now = pick_src(bus.SPEED, bus.OCLK_IN, bus.CLK1_IN, bus.CLK2_IN);
        c1_old  = c1_now;
        c1_now  = bus.CLK1_IN;
        m_speed_prev = int'(bus.SPEED);

        m_en = 0;
        if (bus.HALT_REQ) begin
            m_mode = ModeIdle;
        end else if (active && (bus.HALT_IN || (tick && hit))) begin
            m_mode = ModeHalted;
        end else if (m_mode == ModeIdle && bus.RUN_REQ) begin
            m_mode = ModeRun;  m_skip = 1;
        end else if (m_mode == ModeIdle && press) begin
            m_mode = ModeStep; m_skip = 1;
        end else if (active && tick) begin
            m_en     = 1;
            m_skip   = 0;
            m_cycles = (m_cycles + 1) % (1 << CntW);
            if (m_mode == ModeStep) m_mode = ModeIdle;
        end
    endtask

    always @(posedge CLK) begin
        if (nRST === 1'b1) model_edge();
        exp_q.push_back('{en: m_en, st: 2'(m_mode), cyc: CntW'(m_cycles)});
    end

    always @(negedge nRST) begin
        model_reset();
        exp_q.delete();
    end

    // Monitor: the DUT presents STATE/CPU_EN/CYCLES every cycle.
    always @(negedge CLK) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("cpu_en",  32'(bus.CPU_EN),  32'(e.en));
            check("state",   32'(bus.STATE),   32'(e.st));
            check("running", 32'(bus.RUNNING), 32'(e.st == 2'b01));
            check("cycles",  32'(bus.CYCLES),  32'(e.cyc));
        end
        if (bus.CPU_EN === 1'b1) strobes++;
        if (bus.STATE == 2'b10 && st_prev != 2'b10) step_entries++;
        st_prev = bus.STATE;
    end

    // Behavioural CPU: PC reflects the next instruction once a strobe is seen.
    always @(posedge CLK) begin
        #2;
        if (!pc_follow)              bus.PC = pc_set;
        else if (bus.CPU_EN === 1'b1) bus.PC = bus.PC + 32'd4;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
            cyc++;
            bus.OCLK_IN = 1'((cyc / 2) % 2);
            bus.CLK1_IN = 1'((cyc / 8) % 2);
            bus.CLK2_IN = 1'((cyc / 20) % 2);
        end
    endtask

    task automatic pulse_run();
        bus.RUN_REQ = 1'b1; step(1); bus.RUN_REQ = 1'b0;
    endtask

    task automatic pulse_halt();
        bus.HALT_REQ = 1'b1; step(1); bus.HALT_REQ = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int s0, c0, e0;
        bit pat[7];
        model_reset();
        nRST = 1'b0;
        bus.OCLK_IN = 0; bus.CLK1_IN = 0; bus.CLK2_IN = 0; bus.SPEED = 2'b11;
        bus.RUN_REQ = 0; bus.HALT_REQ = 0; bus.STEP_BTN = 0; bus.HALT_IN = 0;
        bus.BP_EN = 0; bus.BP_ADDR = 32'd0;
        step(3);
        check("rst_cpu_en",  32'(bus.CPU_EN),  32'd0);
        check("rst_state",   32'(bus.STATE),   32'd0);
        check("rst_running", 32'(bus.RUNNING), 32'd0);
        check("rst_cycles",  32'(bus.CYCLES),  32'd0);
        nRST = 1'b1;
        step(2);

        // Full-speed run/stop.
        s0 = strobes;
        pulse_run();
        step(19);
        pulse_halt();
        check("fs_strobes", 32'(strobes - s0), 32'd19);
        check("fs_cycles",  32'(bus.CYCLES),   32'(19 % (1 << CntW)));
        check("fs_state",   32'(bus.STATE),    32'd0);

        // Divided rates: one strobe per source period.
        bus.SPEED = 2'b01;
        step(2);
        pulse_run();
        step(20);
        s0 = strobes;
        step(160);
        check("clk1_rate", 32'(strobes - s0), 32'd10);
        bus.SPEED = 2'b10;
        step(50);
        s0 = strobes;
        step(200);
        check("clk2_rate", 32'(strobes - s0), 32'd5);
        pulse_halt();
        step(2);

        // Debounced step: bounces rejected, one accepted press gives one strobe.
        bus.SPEED = 2'b01;
        pat = '{1, 0, 1, 0, 1, 1, 1};
        s0 = strobes; e0 = step_entries; c0 = int'(bus.CYCLES);
        foreach (pat[i]) begin
            bus.STEP_BTN = pat[i];
            step(16);
        end
        step(40);
        check("dbn_entries", 32'(step_entries - e0), 32'd1);
        check("dbn_strobes", 32'(strobes - s0),      32'd1);
        check("dbn_cycles",  32'(bus.CYCLES),        32'((c0 + 1) % (1 << CntW)));
        check("dbn_state",   32'(bus.STATE),         32'd0);
        bus.STEP_BTN = 1'b0;
        step(64);
        e0 = step_entries;
        pulse_run();
        bus.STEP_BTN = 1'b1;
        step(64);
        pulse_halt();
        step(40);
        check("press_in_run", 32'(step_entries - e0), 32'd0);
        check("press_idle",   32'(bus.STATE),         32'd0);
        bus.STEP_BTN = 1'b0;
        step(64);

        // Breakpoint at 0x10 with skip on resume.
        bus.SPEED = 2'b11;
        pc_follow = 1'b1;
        bus.BP_EN = 1'b1; bus.BP_ADDR = 32'h10;
        step(3);
        s0 = strobes;
        pulse_run();
        step(10);
        check("bp_strobes", 32'(strobes - s0), 32'd4);
        check("bp_state",   32'(bus.STATE),    32'd3);
        check("bp_pc",      bus.PC,            32'h10);
        pulse_run();
        step(3);
        check("bp_run_ign", 32'(bus.STATE), 32'd3);
        pulse_halt();
        check("bp_idle", 32'(bus.STATE), 32'd0);
        pulse_run();
        step(4);
        #5;
        check("bp_resume_pc", bus.PC,         32'h20);
        check("bp_resume_st", 32'(bus.STATE), 32'd1);
        pulse_halt();
        bus.BP_EN = 1'b0;
        pc_follow = 1'b0;
        step(2);

        // HALT_IN beats tick; HALT_REQ beats RUN_REQ.
        pulse_run();
        step(3);
        bus.HALT_IN = 1'b1;
        step(1);
        bus.HALT_IN = 1'b0;
        check("hin_cpu_en", 32'(bus.CPU_EN), 32'd0);
        check("hin_state",  32'(bus.STATE),  32'd3);
        pulse_halt();
        bus.HALT_REQ = 1'b1; bus.RUN_REQ = 1'b1;
        step(2);
        bus.HALT_REQ = 1'b0; bus.RUN_REQ = 1'b0;
        check("prio_state",  32'(bus.STATE),  32'd0);
        check("prio_cpu_en", 32'(bus.CPU_EN), 32'd0);

        // Counter wrap after 17 strobes, then asynchronous reset mid-run.
        nRST = 1'b0; step(2); nRST = 1'b1; step(2);
        s0 = strobes;
        pulse_run();
        step(17);
        pulse_halt();
        check("wrap_strobes", 32'(strobes - s0), 32'd17);
        check("wrap_cycles",  32'(bus.CYCLES),   32'(17 % (1 << CntW)));
        pulse_run();
        step(5);
        nRST = 1'b0;
        #1;
        check("arst_cpu_en", 32'(bus.CPU_EN), 32'd0);
        check("arst_state",  32'(bus.STATE),  32'd0);
        check("arst_cycles", 32'(bus.CYCLES), 32'd0);
        step(2);
        nRST = 1'b1;
        step(2);

        // Randomized traffic against the model.
        pc_follow = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(19) == 0) bus.SPEED = 2'($urandom_range(3));
            bus.RUN_REQ  = ($urandom_range(14) == 0);
            bus.HALT_REQ = ($urandom_range(39) == 0);
            bus.HALT_IN  = ($urandom_range(59) == 0);
            if ($urandom_range(39) == 0) bus.STEP_BTN = ~bus.STEP_BTN;
            if ($urandom_range(49) == 0) begin
                bus.BP_EN   = 1'($urandom_range(1));
                bus.BP_ADDR = bus.PC + 32'(4 * $urandom_range(6));
            end
            if ($urandom_range(599) == 0) begin
                nRST = 1'b0; step(1); nRST = 1'b1;
            end
            step(1);
        end
        bus.RUN_REQ = 0; bus.HALT_REQ = 0; bus.HALT_IN = 0;
        step(3);
        #5;
        check("sb_drain", 32'(exp_q.size() <= 1), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Run-control sequencer for the single-cycle CPU. It takes the divided clocks produced by the frequency divider, selects one as the CPU step rate, and issues a one-CLK-wide `CPU_EN` strobe per CPU cycle. Strobes are gated by run/halt/single-step requests, a debounced step button, a CPU halt signal and a PC breakpoint. It sits between the divider and the CPU datapath's clock-enable input and replaces direct clocking of the CPU from a divided clock.

## Interface
- `DEB_SAMPLES`, default 3: number of consecutive equal 50 Hz samples needed to accept a new step-button level (1..15).
- `CNT_W`, default 16: width of the executed-cycle counter.

- `CLK` in 1: system clock; every flop is in this domain.
- `nRST` in 1: asynchronous, active-low reset.
- `OCLK_IN` in 1: fast divided clock from the divider.
- `CLK1_IN` in 1: 50 Hz divided clock; also the debounce sample rate.
- `CLK2_IN` in 1: 10 Hz divided clock.
- `SPEED` in 2: step-rate select. 00 = OCLK_IN, 01 = CLK1_IN, 10 = CLK2_IN, 11 = every CLK.
- `RUN_REQ` in 1: level, start free-running.
- `HALT_REQ` in 1: level, stop and return to IDLE.
- `STEP_BTN` in 1: raw, bouncy step push-button, active-high.
- `HALT_IN` in 1: CPU reports a halt instruction (level).
- `BP_EN` in 1: breakpoint enable.
- `BP_ADDR` in 32: breakpoint PC.
- `PC` in 32: current CPU PC.
- `CPU_EN` out 1: registered one-CLK strobe; the CPU commits one instruction per strobe.
- `STATE` out 2: IDLE = 00, RUN = 01, STEP = 10, HALTED = 11.
- `RUNNING` out 1: `STATE == RUN`.
- `CYCLES` out CNT_W: count of `CPU_EN` strobes issued.

## Operation
- **Reset values.** `CPU_EN` = 0, `STATE` = IDLE, `RUNNING` = 0, `CYCLES` = 0. All sync/edge flops and the debounce counter are 0, and the stable button level is 0.
- **Tick generation.**
  - The selected source passes through two flops, s1 and s2. `tick = s1 & ~s2`.
  - When `SPEED` = 11, `tick` = 1 every cycle.
  - `SPEED` is registered each cycle as `SPEED_q`. `tick` is forced to 0 in any cycle where `SPEED != SPEED_q`, so a rate change never produces a spurious tick.
- **Debounce.**
  - On each rising edge of `CLK1_IN` (its own s1/s2 pair, independent of `SPEED`), sample `STEP_BTN`.
  - If the sample differs from the stable level, increment the counter. Otherwise clear the counter.
  - When the counter reaches `DEB_SAMPLES`, the stable level takes the sample and the counter clears.
  - A stable 0→1 transition gives `press`, an internal one-CLK pulse. Releases produce nothing.
- **Breakpoint hit.** `hit = BP_EN & (PC == BP_ADDR) & ~skip`.
  - `skip` is set on every entry to RUN or STEP and cleared on the next `CPU_EN`.
  - This lets execution resume from a breakpointed PC.
- **Transitions** (evaluated each CLK; priority top to bottom):
  - Any state, `HALT_REQ` = 1: go to IDLE, no strobe.
  - RUN or STEP with `HALT_IN` = 1: go to HALTED, no strobe.
  - RUN or STEP with `tick & hit`: go to HALTED, no strobe.
  - IDLE with `RUN_REQ`: go to RUN.
  - IDLE with `press` (and no `RUN_REQ`): go to STEP.
  - RUN with `tick`: `CPU_EN` <= 1, stay in RUN.
  - STEP with `tick`: `CPU_EN` <= 1, go to IDLE.
  - HALTED: ignores `RUN_REQ`, `press` and `tick`. It exits only via `HALT_REQ` or reset.
- **Other rules.**
  - A `press` arriving in RUN, STEP or HALTED is discarded, not queued.
  - `CYCLES` increments on each `CPU_EN` and wraps from 2^CNT_W−1 to 0. Only `nRST` clears it.

## Timing
- `CPU_EN` latency from a source rise:
  - Source rises before edge e; s1 = 1 after e.
  - `CPU_EN` is high for exactly the one cycle after edge e+1.
  - Latency is 2 CLK edges.
- At `SPEED` = 11:
  - `RUN_REQ` sampled at edge k moves to RUN after k.
  - `CPU_EN` is high continuously from after edge k+1.
- `HALT_REQ` or `HALT_IN` sampled at edge k: no `CPU_EN` after k. A strobe already high in cycle k completes normally.
- `STATE`, `RUNNING` and `CYCLES` are registered and update on the same edge as the transition or strobe that causes them.
- `nRST` low mid-run: `CPU_EN` drops immediately (asynchronous); state returns to IDLE.

## Test plan
- **Full-speed run/stop.** `SPEED` = 11, `RUN_REQ` pulse at edge 10, `HALT_REQ` at edge 30. Expect `CPU_EN` high for 19 cycles (after edges 11..29), `CYCLES` = 19, `STATE` = IDLE after edge 30.
- **Divided rate.** `SPEED` = 01, `CLK1_IN` toggling every 8 CLK, RUN. Expect one `CPU_EN` per 16 CLK, each appearing 2 edges after the `CLK1_IN` rise. Changing `SPEED` to 10 mid-run gives no extra strobe in the switch cycle.
- **Debounced step.** `DEB_SAMPLES` = 3, `STEP_BTN` bouncing 1/0/1/0 across 50 Hz samples, then held at 1 for 3 samples. Expect exactly one STEP entry, one `CPU_EN` on the next tick, then IDLE and `CYCLES` = 1. Press during RUN is ignored.
- **Breakpoint.** `BP_EN` = 1, `BP_ADDR` = 0x0000_0010, PC advancing +4 per strobe from 0, `SPEED` = 11. Expect 4 strobes, then HALTED with PC = 0x10. `RUN_REQ` is ignored there. After `HALT_REQ` then `RUN_REQ`, expect a strobe at PC 0x10 (skip) and continued execution.
- **Halt input and priority.** `HALT_IN` and `tick` in the same cycle in RUN: no strobe, HALTED. `HALT_REQ` and `RUN_REQ` together in IDLE: stays IDLE.
- **Wrap and reset.** `CNT_W` = 4, 17 strobes: `CYCLES` = 1. `nRST` low mid-RUN: `CPU_EN` = 0 and `STATE` = 00 immediately.
